// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow_ctrl FIFO flow-control FSM.
// State indices, one-hot state vector width and the state enum live here so
// the top and any debug consumers of state_o agree on the encoding.
package flow_ctrl_pkg;

  localparam int unsigned STATE_W   = 7;
  localparam int unsigned ERR_CNT_W = 8;

  localparam int unsigned S_RESET          = 0;
  localparam int unsigned S_ERROR          = 1;
  localparam int unsigned S_INIT           = 2;
  localparam int unsigned S_IDLE_EMPTY     = 3;
  localparam int unsigned S_PAUSE          = 4;
  localparam int unsigned S_CONTINUE_STATE = 5;
  localparam int unsigned S_ACTIVE         = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET    = STATE_W'(1 << S_RESET),
    ST_ERROR    = STATE_W'(1 << S_ERROR),
    ST_INIT     = STATE_W'(1 << S_INIT),
    ST_IDLE     = STATE_W'(1 << S_IDLE_EMPTY),
    ST_PAUSE    = STATE_W'(1 << S_PAUSE),
    ST_CONTINUE = STATE_W'(1 << S_CONTINUE_STATE),
    ST_ACTIVE   = STATE_W'(1 << S_ACTIVE)
  } state_e;

endpackage

// File: rtl/fc_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the PAUSE dwell
// counter and the optional ERROR-entry counter. Clear wins over increment.
module fc_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enb,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register: async active-low reset, holds when enb is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (enb) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != '1)) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/flow_ctrl.sv
// flow_ctrl: watches per-FIFO status flags and issues pause/continue/error
// commands through a one-hot FSM. Outputs are registered from the next state.
// Optional build macro FLOW_CTRL_ERR_CNT_EN adds the err_cnt output.
module flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int unsigned N_CH  = 5,
  parameter int unsigned TMO_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic               iniciar,
  input  logic               clr_error,
  input  logic [TMO_W-1:0]   pause_tmo,
  input  logic [N_CH-1:0]    almost_full,
  input  logic [N_CH-1:0]    full,
  input  logic [N_CH-1:0]    almost_empty,
  input  logic [N_CH-1:0]    empty,
  output logic [N_CH-1:0]    continuar,
  output logic [N_CH-1:0]    pausa,
  output logic [N_CH-1:0]    error_full,
  output logic               idle,
  output logic               tmo_err,
  output logic [STATE_W-1:0] state_o
`ifdef FLOW_CTRL_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_e           state, state_nxt;
  logic [TMO_W-1:0] dwell_cnt, dwell_now;
  logic             tmo_hit, tmo_entry, err_entry;
  logic [N_CH-1:0]  continuar_d, pausa_d, error_full_d;
  logic             idle_d, tmo_err_d;

  // dwell_now counts PAUSE cycles including the current one, so a timeout of
  // N leaves PAUSE after exactly N cycles of pausa.
  always_comb begin
    dwell_now = (dwell_cnt == '1) ? dwell_cnt : dwell_cnt + TMO_W'(1);
    tmo_hit   = (pause_tmo != '0) && (dwell_now == pause_tmo);
  end

  // Next-state selection; full always has top priority.
  always_comb begin
    state_nxt = state;
    tmo_entry = 1'b0;
    case (state)
      ST_RESET:    state_nxt = ST_INIT;
      ST_INIT:     if (iniciar) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (|full)       state_nxt = ST_ERROR;
        else if (|empty) state_nxt = ST_IDLE;
        else             state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|full)              state_nxt = ST_ERROR;
        else if (|almost_full)  state_nxt = ST_PAUSE;
        else if (|empty)        state_nxt = ST_IDLE;
        else if (|almost_empty) state_nxt = ST_CONTINUE;
        else                    state_nxt = ST_ACTIVE;
      end
      ST_CONTINUE: state_nxt = (|full) ? ST_ERROR : ST_ACTIVE;
      ST_PAUSE: begin
        if (|full) begin
          state_nxt = ST_ERROR;
        end else if (tmo_hit) begin
          state_nxt = ST_ERROR;
          tmo_entry = 1'b1;
        end else if (|almost_full) begin
          state_nxt = ST_PAUSE;
        end else begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ERROR:    if (clr_error) state_nxt = ST_INIT;
      default:     state_nxt = ST_RESET;
    endcase
  end

  // Output values for the state being entered; error flags are captured on
  // ERROR entry and held while ERROR persists.
  always_comb begin
    err_entry    = (state_nxt == ST_ERROR) && (state != ST_ERROR);
    continuar_d  = (state_nxt == ST_CONTINUE) ? almost_empty : '0;
    pausa_d      = (state_nxt == ST_PAUSE) ? almost_full : '0;
    idle_d       = (state_nxt == ST_IDLE);
    error_full_d = '0;
    tmo_err_d    = 1'b0;
    if (err_entry) begin
      error_full_d = full;
      tmo_err_d    = tmo_entry;
    end else if (state_nxt == ST_ERROR) begin
      error_full_d = error_full;
      tmo_err_d    = tmo_err;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RESET;
      continuar  <= '0;
      pausa      <= '0;
      error_full <= '0;
      idle       <= 1'b0;
      tmo_err    <= 1'b0;
    end else if (enb) begin
      state      <= state_nxt;
      continuar  <= continuar_d;
      pausa      <= pausa_d;
      error_full <= error_full_d;
      idle       <= idle_d;
      tmo_err    <= tmo_err_d;
    end
  end

  assign state_o = state;

  fc_sat_counter #(.W(TMO_W)) u_dwell (
    .clk (clk),
    .rst (rst),
    .enb (enb),
    .clr ((state_nxt == ST_PAUSE) && (state != ST_PAUSE)),
    .inc (state == ST_PAUSE),
    .cnt (dwell_cnt)
  );

`ifdef FLOW_CTRL_ERR_CNT_EN
  fc_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .enb (enb),
    .clr (1'b0),
    .inc (err_entry),
    .cnt (err_cnt)
  );
`endif

endmodule

// File: tb/tb_flow_ctrl.sv
// Scoreboard bench for flow_ctrl: the driver pushes hand-computed expected
// outputs after each edge, the monitor pops and compares on the falling edge.
module tb_flow_ctrl;

  localparam logic [6:0] E_RST  = 7'b0000001;
  localparam logic [6:0] E_ERR  = 7'b0000010;
  localparam logic [6:0] E_INI  = 7'b0000100;
  localparam logic [6:0] E_IDL  = 7'b0001000;
  localparam logic [6:0] E_PAU  = 7'b0010000;
  localparam logic [6:0] E_CON  = 7'b0100000;
  localparam logic [6:0] E_ACT  = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst, enb, iniciar, clr_error;
  logic [7:0] pause_tmo;
  logic [4:0] almost_full, full, almost_empty, empty;
  logic [4:0] continuar, pausa, error_full;
  logic       idle, tmo_err;
  logic [6:0] state_o;
`ifdef FLOW_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  typedef struct packed {
    logic [6:0] st;
    logic [4:0] cont;
    logic [4:0] pau;
    logic [4:0] ef;
    logic       idl;
    logic       te;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  flow_ctrl #(.N_CH(5), .TMO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .iniciar      (iniciar),
    .clr_error    (clr_error),
    .pause_tmo    (pause_tmo),
    .almost_full  (almost_full),
    .full         (full),
    .almost_empty (almost_empty),
    .empty        (empty),
    .continuar    (continuar),
    .pausa        (pausa),
    .error_full   (error_full),
    .idle         (idle),
    .tmo_err      (tmo_err),
    .state_o      (state_o)
`ifdef FLOW_CTRL_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  task automatic push(input string nm, input logic [6:0] st, input logic [4:0] cont,
                      input logic [4:0] pau, input logic [4:0] ef, input logic idl, input logic te);
    exp_t e;
    e.st = st; e.cont = cont; e.pau = pau; e.ef = ef; e.idl = idl; e.te = te;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [6:0] st, input logic [4:0] cont,
                     input logic [4:0] pau, input logic [4:0] ef, input logic idl, input logic te);
    @(posedge clk);
    #1;
    push(nm, st, cont, pau, ef, idl, te);
  endtask

  // Monitor: compare the DUT outputs against the oldest pending expectation.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        a.st = state_o; a.cont = continuar; a.pau = pausa; a.ef = error_full;
        a.idl = idle; a.te = tmo_err;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got st=%b cont=%b pau=%b ef=%b idle=%b tmo=%b, want st=%b cont=%b pau=%b ef=%b idle=%b tmo=%b",
                   nm, a.st, a.cont, a.pau, a.ef, a.idl, a.te,
                   e.st, e.cont, e.pau, e.ef, e.idl, e.te);
        end
      end
    end
  end

`ifdef FLOW_CTRL_ERR_CNT_EN
  task automatic err_once();
    iniciar = 1'b1; @(posedge clk); #1;
    iniciar = 1'b0; @(posedge clk); #1;
    full = 5'b00001; @(posedge clk); #1;
    full = 5'b00000; clr_error = 1'b1; @(posedge clk); #1;
    clr_error = 1'b0;
  endtask

  task automatic chk_cnt(input string nm, input logic [7:0] want);
    @(negedge clk);
    checks++;
    if (err_cnt !== want) begin
      errors++;
      $display("FAIL %s: got err_cnt=%0d want %0d", nm, err_cnt, want);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enb = 1'b1; iniciar = 1'b0; clr_error = 1'b0; pause_tmo = 8'd0;
    almost_full = '0; full = '0; almost_empty = '0; empty = '0;

    repeat (3) chk("reset", E_RST, 0, 0, 0, 0, 0);
    rst = 1'b1; iniciar = 1'b1;
    chk("to_init", E_INI, 0, 0, 0, 0, 0);
    chk("to_idle", E_IDL, 0, 0, 0, 1, 0);
    iniciar = 1'b0; empty = 5'b00001;
    chk("idle_hold", E_IDL, 0, 0, 0, 1, 0);
    empty = '0;
    chk("to_active", E_ACT, 0, 0, 0, 0, 0);
    clr_error = 1'b1;
    chk("clr_ignored", E_ACT, 0, 0, 0, 0, 0);
    clr_error = 1'b0; enb = 1'b0; almost_empty = 5'b10000;
    chk("enb_hold", E_ACT, 0, 0, 0, 0, 0);
    enb = 1'b1;
    chk("continue", E_CON, 5'b10000, 0, 0, 0, 0);
    almost_empty = '0;
    chk("cont_exit", E_ACT, 0, 0, 0, 0, 0);

    full = 5'b00100; almost_full = 5'b00011;
    chk("priority", E_ERR, 0, 0, 5'b00100, 0, 0);
    full = '0; almost_full = '0;
    chk("err_sticky", E_ERR, 0, 0, 5'b00100, 0, 0);
    clr_error = 1'b1;
    chk("err_clr", E_INI, 0, 0, 0, 0, 0);
    clr_error = 1'b0; iniciar = 1'b1;
    chk("idle2", E_IDL, 0, 0, 0, 1, 0);
    iniciar = 1'b0;
    chk("active2", E_ACT, 0, 0, 0, 0, 0);

    pause_tmo = 8'd4; almost_full = 5'b00001;
    repeat (4) chk("pause_tmo", E_PAU, 0, 5'b00001, 0, 0, 0);
    chk("timeout", E_ERR, 0, 0, 0, 0, 1);
    chk("tmo_sticky", E_ERR, 0, 0, 0, 0, 1);
    almost_full = '0; clr_error = 1'b1;
    chk("tmo_clr", E_INI, 0, 0, 0, 0, 0);
    clr_error = 1'b0; iniciar = 1'b1;
    chk("idle3", E_IDL, 0, 0, 0, 1, 0);
    iniciar = 1'b0;
    chk("active3", E_ACT, 0, 0, 0, 0, 0);
    almost_full = 5'b00010;
    chk("pause_short", E_PAU, 0, 5'b00010, 0, 0, 0);
    almost_full = '0;
    chk("pause_exit", E_ACT, 0, 0, 0, 0, 0);

    pause_tmo = 8'd0; almost_full = 5'b01000;
    repeat (5) chk("pause_notmo", E_PAU, 0, 5'b01000, 0, 0, 0);
    full = 5'b00001;
    chk("pause_full", E_ERR, 0, 0, 5'b00001, 0, 0);
    full = '0; almost_full = '0; clr_error = 1'b1;
    chk("clr4", E_INI, 0, 0, 0, 0, 0);
    clr_error = 1'b0; iniciar = 1'b1;
    chk("idle4", E_IDL, 0, 0, 0, 1, 0);
    iniciar = 1'b0; empty = 5'b11111; full = 5'b10000;
    chk("idle_full", E_ERR, 0, 0, 5'b10000, 0, 0);
    full = '0; empty = '0; clr_error = 1'b1;
    chk("clr5", E_INI, 0, 0, 0, 0, 0);
    clr_error = 1'b0; iniciar = 1'b1;
    chk("idle5", E_IDL, 0, 0, 0, 1, 0);
    iniciar = 1'b0;
    chk("active5", E_ACT, 0, 0, 0, 0, 0);

    // Reset asserted between edges while in PAUSE must act before the next edge.
    pause_tmo = 8'd4; almost_full = 5'b00001;
    chk("pause_pre_rst", E_PAU, 0, 5'b00001, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    push("async_rst", E_RST, 0, 0, 0, 0, 0);
    almost_full = '0;
    chk("rst_hold", E_RST, 0, 0, 0, 0, 0);
    rst = 1'b1;
    chk("rel_init", E_INI, 0, 0, 0, 0, 0);
    chk("init_hold", E_INI, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end

`ifdef FLOW_CTRL_ERR_CNT_EN
    chk_cnt("err_cnt_rst", 8'd0);
    repeat (3) err_once();
    chk_cnt("err_cnt_3", 8'd3);
    repeat (297) err_once();
    chk_cnt("err_cnt_sat", 8'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
